viterbi_decoder_k3: RTL
=======================

// Module: viterbi_decoder_k3
// PURPOSE
//  Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (G1=3'b110, G2=3'b111).
//  Consumes the 2-bit parity symbols produced by Convolutional_Encoder and recovers the source bit stream.
//  4-state trellis, register-exchange survivor memory, fixed decision depth. Sits directly downstream of the encoder.
// PARAMETERS
//  DEPTH      15  survivor length / decision delay in symbols (>=5)
//  PM_W       5   path-metric width; metrics saturate at 2**PM_W-1
//  INIT_BIAS  8   starting metric of states 1..3 (state 0 starts at 0)
// PORTS
//  CLK        in   1  clock, all state updates on posedge
//  RST        in   1  synchronous, active-high reset
//  clr        in   1  synchronous frame restart; same effect as RST on datapath state
//  sym_in     in   2  received symbol: [0]=parity G1, [1]=parity G2 (encoder parities[1:0])
//  sym_valid  in   1  sym_in valid this cycle; one symbol accepted per asserted edge
//  dec_bit    out  1  decoded bit, oldest in survivor of best state
//  dec_valid  out  1  1-cycle pulse per decoded bit
// BEHAVIOUR
//  - Clock is CLK; reset RST is synchronous, active-high. Reset: metric[0]=0, metric[1..3]=INIT_BIAS,
//    histories=0, sym_cnt=0, dec_bit=0, dec_valid=0. clr identical; clr has priority over sym_valid (symbol dropped).
//  - Encoder model: bits b_n; emitted symbol p0=b_n^b_{n-1}, p1=b_n^b_{n-1}^b_{n-2}.
//    State s={b_{n-1},b_{n-2}} (bit1=b_{n-1}); next state {b_n,b_{n-1}}. Encoder starts in state 0.
//  - Predecessors of new state {x,y}: {y,0} and {y,1}. Branch metric = Hamming distance(sym_in, expected), 0..2.
//  - ACS per new state: cand = metric[pred]+bm (saturating at 2**PM_W-1); pick smaller;
//    tie -> predecessor with b_{n-2}=0 (lower index).
//  - Normalisation: after ACS subtract min of the 4 new metrics from all four, so min is always 0.
//  - Survivor: hist[new] <= {hist[pred][DEPTH-2:0], x}; DEPTH bits per state; bit DEPTH-1 is oldest.
//  - sym_valid=0: no metric/history/count change; dec_valid=0. Gaps of any length are allowed.
//  - sym_cnt saturates at DEPTH-1. On accept edge for symbol n (0-based) with n>=DEPTH-1:
//    dec_bit <= next_hist[best][DEPTH-1], dec_valid <= 1; best = state with min next metric, lowest index on tie.
//    dec_bit is b_{n-DEPTH+1}. Otherwise dec_valid <= 0. Latency: one edge, DEPTH symbols deep.
//  - Decoded bits emerge in order, exactly one per accepted symbol after fill; no backpressure.
//  - RST/clr mid-frame: all in-flight history discarded; next symbol is treated as symbol 0 from state 0.
//  - Final DEPTH-1 bits of a frame are only released by feeding flush symbols (encoder fed zeros).
// STRUCTURE
//  - Package viterbi_k3_pkg: K=3, NSTATES=4, G1=3'b110, G2=3'b111, function exp_sym(state,bit) -> 2-bit symbol.
//  - Sub-module viterbi_acs (one instance per state): two metrics + two branch metrics in,
//    new metric + decision bit out, saturating add and tie rule inside.
//  - Top: branch-metric units, 4x viterbi_acs, min-finder/normaliser, survivor regs, count, output regs.
// TESTING
//  - All-zero stream, 40 symbols 2'b00 -> dec_valid from 15th accept edge, every dec_bit=0.
//  - Bits 1,0,1,1 then zeros; sym_in={p1,p0}=11,11,01,00,01,10,00.. -> dec_bit sequence 1,0,1,1,0...
//  - Same stream with one bit flipped in symbol 2 (01->00) -> identical decoded sequence.
//  - sym_valid gaps of 0..5 idle cycles between symbols -> same output, dec_valid only after accepting edges.
//  - RST (and separately clr together with sym_valid) after 20 symbols -> outputs 0, next fill needs 15 new symbols.
//  - 200 random encoder bits via Convolutional_Encoder, <=1 error per 6 symbols -> zero bit errors vs delayed source.

Source files
------------

// File: rtl/viterbi_k3_pkg.sv
// rtl/viterbi_k3_pkg.sv - Trellis constants and symbol helpers for the K=3 Viterbi decoder
package viterbi_k3_pkg;
    localparam int K = 3;
    localparam int NSTATES = 4;
    localparam logic [K-1:0] G1 = 3'b110;
    localparam logic [K-1:0] G2 = 3'b111;

    // state = {b_{n-1}, b_{n-2}}; result is {p1, p0} as carried on sym_in
    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic b);
        logic [K-1:0] taps;
        taps = {b, state};
        return {^(taps & G2), ^(taps & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction
endpackage

// File: rtl/viterbi_acs.sv
// rtl/viterbi_acs.sv - Add-compare-select for one trellis state with saturating metrics
module viterbi_acs #(
    parameter int PM_W = 5
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_a,
    input  logic [1:0]      bm_b,
    output logic [PM_W-1:0] pm_out,
    output logic            dec
);
    localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

    logic [PM_W:0]   sum_a;
    logic [PM_W:0]   sum_b;
    logic [PM_W-1:0] cand_a;
    logic [PM_W-1:0] cand_b;

    // Predecessor a has b_{n-2}=0, so ties resolve towards it
    always_comb begin
        sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
        sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
        cand_a = (sum_a > PM_MAX) ? PM_MAX[PM_W-1:0] : sum_a[PM_W-1:0];
        cand_b = (sum_b > PM_MAX) ? PM_MAX[PM_W-1:0] : sum_b[PM_W-1:0];
        dec    = (cand_b < cand_a);
        pm_out = dec ? cand_b : cand_a;
    end
endmodule

// File: rtl/viterbi_decoder_k3.sv
// rtl/viterbi_decoder_k3.sv - Hard-decision register-exchange Viterbi decoder, rate 1/2, K=3
module viterbi_decoder_k3
    import viterbi_k3_pkg::*;
#(
    parameter int DEPTH     = 15,
    parameter int PM_W      = 5,
    parameter int INIT_BIAS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic       dec_bit,
    output logic       dec_valid
);
    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);
    localparam logic [PM_W-1:0]  BIAS    = PM_W'(INIT_BIAS);
    localparam logic [NSTATES-1:0][PM_W-1:0] METRIC_INIT = {BIAS, BIAS, BIAS, {PM_W{1'b0}}};

    logic [NSTATES-1:0][PM_W-1:0]  metric_q, metric_d, acs_pm, norm_pm;
    logic [NSTATES-1:0][DEPTH-1:0] hist_q, hist_d, pred_hist, new_hist;
    logic [NSTATES-1:0]            acs_dec;
    logic [NSTATES-1:0][1:0][1:0]  bm;
    logic [CNT_W-1:0]              sym_cnt_q, sym_cnt_d;
    logic                          dec_bit_q, dec_bit_d, dec_valid_q, dec_valid_d;
    logic [PM_W-1:0]               pm_min;
    logic [1:0]                    best;

    // bm[s][b]: distance from sym_in to the symbol emitted leaving state s with input b
    always_comb begin
        for (int s = 0; s < NSTATES; s++) begin
            bm[s][0] = hamming2(sym_in, exp_sym(2'(s), 1'b0));
            bm[s][1] = hamming2(sym_in, exp_sym(2'(s), 1'b1));
        end
    end

    for (genvar ns = 0; ns < NSTATES; ns++) begin : g_acs
        localparam int PA = 2 * (ns % 2);
        localparam int PB = PA + 1;
        localparam int X  = ns / 2;
        localparam logic X_BIT = 1'(X);

        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm_a   (metric_q[PA]),
            .pm_b   (metric_q[PB]),
            .bm_a   (bm[PA][X]),
            .bm_b   (bm[PB][X]),
            .pm_out (acs_pm[ns]),
            .dec    (acs_dec[ns])
        );

        assign pred_hist[ns] = acs_dec[ns] ? hist_q[PB] : hist_q[PA];
        assign new_hist[ns]  = {pred_hist[ns][DEPTH-2:0], X_BIT};
    end

    always_comb begin
        pm_min = acs_pm[0];
        best   = 2'd0;
        for (int s = 1; s < NSTATES; s++) begin
            if (acs_pm[s] < pm_min) begin
                pm_min = acs_pm[s];
                best   = 2'(s);
            end
        end
        for (int s = 0; s < NSTATES; s++) begin
            norm_pm[s] = acs_pm[s] - pm_min;
        end
    end

    always_comb begin
        metric_d    = metric_q;
        hist_d      = hist_q;
        sym_cnt_d   = sym_cnt_q;
        dec_bit_d   = dec_bit_q;
        dec_valid_d = 1'b0;
        if (clr) begin
            metric_d  = METRIC_INIT;
            hist_d    = '0;
            sym_cnt_d = '0;
            dec_bit_d = 1'b0;
        end else if (sym_valid) begin
            metric_d = norm_pm;
            hist_d   = new_hist;
            if (sym_cnt_q == CNT_MAX) begin
                dec_bit_d   = new_hist[best][DEPTH-1];
                dec_valid_d = 1'b1;
            end else begin
                sym_cnt_d = sym_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            metric_q    <= METRIC_INIT;
            hist_q      <= '0;
            sym_cnt_q   <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
        end else begin
            metric_q    <= metric_d;
            hist_q      <= hist_d;
            sym_cnt_q   <= sym_cnt_d;
            dec_bit_q   <= dec_bit_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign dec_bit   = dec_bit_q;
    assign dec_valid = dec_valid_q;
endmodule
